// File: rtl/psum_fault_detector_pkg.sv
// Shared types and width helpers for the partial-sum fault detector.
// The state encoding is shared so checkers and the top agree on it.
package psum_fault_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Same rule the PE array uses: product width plus accumulation growth down a column.
    function automatic int psum_width(input int w, input int a, input int n);
        return w + a + $clog2(n);
    endfunction

endpackage

// File: rtl/psum_fault_detector_column_skew_delay.sv
// Fixed-depth delay line for one column's {valid, expected} word.
// Depth 0 degenerates to a plain wire so column 0 compares in the accept cycle.
module column_skew_delay #(
    parameter int D = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (D == 0) begin : g_wire
        logic w_unused_ok;
        assign w_unused_ok = clk ^ rst_n ^ i_clr;
        assign o_q         = i_d;
    end else begin : g_pipe
        logic [W-1:0] r_pipe [D];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < D; i++) r_pipe[i] <= '0;
            end else if (i_clr) begin
                for (int i = 0; i < D; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < D; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_q = r_pipe[D-1];
    end

endmodule

// File: rtl/psum_fault_detector.sv
// Compares skewed bottom-row partial sums against golden vectors and keeps a
// sticky per-column fault map for the self-recovery logic.
module psum_fault_detector
    import psum_fault_detector_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int TEST_LEN          = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       valid_in,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] expected_in,
    input  logic [SYSTOLIC_SIZE-1:0]                   col_disable,
    output logic                                       busy,
    output logic                                       done,
    output logic [SYSTOLIC_SIZE-1:0]                   fault_map,
    output logic [$clog2(TEST_LEN+1)-1:0]              vec_count
);

    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int VCW = $clog2(TEST_LEN + 1);
    localparam int DCW = (SYSTOLIC_SIZE > 2) ? $clog2(SYSTOLIC_SIZE - 1) : 1;
    localparam logic [VCW-1:0] LAST_VEC   = VCW'(TEST_LEN - 1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(SYSTOLIC_SIZE - 2);

    fsm_state_t r_state;
    fsm_state_t w_next_state;

    logic [VCW-1:0]           r_vec_count;
    logic [DCW-1:0]           r_drain_cnt;
    logic [SYSTOLIC_SIZE-1:0] r_fault_map;
    logic [SYSTOLIC_SIZE-1:0] w_mismatch;
    logic                     w_start_accept;
    logic                     w_vec_accept;
    logic                     w_cmp_active;

    assign w_start_accept = (r_state == ST_IDLE) && start;
    assign w_vec_accept   = (r_state == ST_RUN) && valid_in;
    assign w_cmp_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_RUN;
            ST_RUN:   if (valid_in && (r_vec_count == LAST_VEC))
                          w_next_state = (SYSTOLIC_SIZE == 1) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == LAST_DRAIN) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    // The drain counter runs only in DRAIN so it always enters at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_count <= '0;
            r_drain_cnt <= '0;
            r_fault_map <= '0;
        end else begin
            if (w_start_accept)    r_vec_count <= '0;
            else if (w_vec_accept) r_vec_count <= r_vec_count + 1'b1;

            if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
            else                     r_drain_cnt <= '0;

            if (w_start_accept) r_fault_map <= '0;
            else                r_fault_map <= r_fault_map | w_mismatch;
        end
    end

    // Column j sees a vector j cycles after acceptance, matching the array's skew.
    for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
        logic [PSW:0] w_skew_q;

        column_skew_delay #(
            .D(j),
            .W(PSW + 1)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (w_start_accept),
            .i_d   ({w_vec_accept, expected_in[j*PSW +: PSW]}),
            .o_q   (w_skew_q)
        );

        assign w_mismatch[j] = w_cmp_active && w_skew_q[PSW] && !col_disable[j] &&
                               (psum_in[j*PSW +: PSW] != w_skew_q[PSW-1:0]);
    end

    assign fault_map = r_fault_map;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_psum_fault_detector.sv
// Directed bench for psum_fault_detector: models the array's output skew and
// checks timing of the fault map, drain and done against hand-derived cycles.
module tb_psum_fault_detector;

    localparam int N   = 8;
    localparam int L   = 8;
    localparam int PSW = 19;
    localparam int BW  = N * PSW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid_in = 1'b0;
    logic [BW-1:0] psum_in = '0;
    logic [BW-1:0] expected_in = '0;
    logic [N-1:0]  col_disable = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  fault_map;
    logic [3:0]    vec_count;

    always #5 clk = ~clk;

    psum_fault_detector #(
        .SYSTOLIC_SIZE    (N),
        .WEIGHT_WIDTH     (8),
        .ACTIVATION_WIDTH (8),
        .PARTIAL_SUM_WIDTH(PSW),
        .TEST_LEN         (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .valid_in    (valid_in),
        .psum_in     (psum_in),
        .expected_in (expected_in),
        .col_disable (col_disable),
        .busy        (busy),
        .done        (done),
        .fault_map   (fault_map),
        .vec_count   (vec_count)
    );

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    int   fault_k   = -1;
    int   fault_j   = -1;
    logic hv [0:1023];
    int   hk [0:1023];

    function automatic logic [PSW-1:0] golden(input int k, input int j);
        return PSW'(k * 1103 + j * 4099 + 17);
    endfunction

    // The array's real output: golden, except the one injected stuck-multiplier word.
    function automatic logic [PSW-1:0] array_out(input int k, input int j);
        logic [PSW-1:0] g;
        g = golden(k, j);
        if (k == fault_k && j == fault_j) return g - PSW'(35);
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle's inputs, then advance to #1 after the next rising edge.
    task automatic tick(input logic st, input logic v, input int k);
        start    = st;
        valid_in = v;
        hv[cyc]  = v;
        hk[cyc]  = k;
        for (int j = 0; j < N; j++) begin
            expected_in[j*PSW +: PSW] = v ? golden(k, j) : PSW'($urandom);
            if (cyc >= j && hv[cyc-j] === 1'b1)
                psum_in[j*PSW +: PSW] = array_out(hk[cyc-j], j);
            else
                psum_in[j*PSW +: PSW] = PSW'($urandom);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) done_seen++;
    endtask

    // Start, 8 back-to-back vectors from T0, then drain to DONE at T0+15.
    task automatic run_std(input logic [N-1:0] dis, input logic [N-1:0] fm_mid,
                           input logic [N-1:0] fm_final);
        col_disable = dis;
        tick(1'b1, 1'b0, 0);
        check("start_busy", 32'(busy), 1);
        check("start_clr_fm", 32'(fault_map), 0);
        check("start_clr_vc", 32'(vec_count), 0);
        for (int k = 0; k < L; k++) tick(1'b0, 1'b1, k);
        check("vc_after_last", 32'(vec_count), 8);
        check("fm_t0p8", 32'(fault_map), 0);
        tick(1'b0, 1'b0, 0);
        check("fm_t0p9", 32'(fault_map), 32'(fm_mid));
        repeat (5) tick(1'b0, 1'b0, 0);
        check("drain_done_low", 32'(done), 0);
        check("fm_t0p14", 32'(fault_map), 32'(fm_mid));
        tick(1'b0, 1'b0, 0);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("fm_final", 32'(fault_map), 32'(fm_final));
        tick(1'b0, 1'b0, 0);
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_fm_hold", 32'(fault_map), 32'(fm_final));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            hv[i] = 1'b0;
            hk[i] = 0;
        end

        // Reset values
        repeat (3) tick(1'b0, 1'b0, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fm", 32'(fault_map), 0);
        check("rst_vc", 32'(vec_count), 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 0);

        // All columns match
        run_std(8'h00, 8'h00, 8'h00);

        // Column 3 stuck multiplier on vector 5: visible from t5+4
        fault_k = 5;
        fault_j = 3;
        run_std(8'h00, 8'h08, 8'h08);

        // Same fault with column 3 excluded
        run_std(8'h08, 8'h00, 8'h00);

        // Column 7 of the last vector is compared in the final DRAIN cycle
        fault_k = 7;
        fault_j = 7;
        run_std(8'h00, 8'h00, 8'h80);

        // Gapped vectors, ignored start mid-run, valid_in in IDLE and DRAIN
        col_disable = '0;
        fault_k     = 9;
        fault_j     = 0;
        done_seen   = 0;
        tick(1'b0, 1'b1, 9);
        check("idle_valid_vc", 32'(vec_count), 8);
        check("idle_valid_busy", 32'(busy), 0);
        tick(1'b1, 1'b1, 9);
        check("start_with_valid_vc", 32'(vec_count), 0);
        check("start_with_valid_busy", 32'(busy), 1);
        for (int k = 0; k < L; k++) begin
            tick(1'b0, 1'b1, k);
            if (k == 3)      tick(1'b1, 1'b0, 0);
            else if (k == 7) tick(1'b0, 1'b1, 9);
            else             tick(1'b0, 1'b0, 0);
            tick(1'b0, 1'b0, 0);
            tick(1'b0, 1'b0, 0);
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 0);
        check("gap_done_count", 32'(done_seen), 1);
        check("gap_vc", 32'(vec_count), 8);
        check("gap_fm", 32'(fault_map), 0);
        check("gap_busy", 32'(busy), 0);

        // Reset mid-run aborts with no done pulse
        fault_k   = 0;
        fault_j   = 0;
        done_seen = 0;
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b1, 1);
        check("pre_rst_fm", 32'(fault_map), 32'h01);
        check("pre_rst_vc", 32'(vec_count), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_fm", 32'(fault_map), 0);
        check("mid_rst_vc", 32'(vec_count), 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        rst_n = 1'b1;
        repeat (10) tick(1'b0, 1'b0, 0);
        check("rst_no_done", 32'(done_seen), 0);
        check("rst_idle_busy", 32'(busy), 0);

        // Clean run after reset
        fault_k = -1;
        fault_j = -1;
        run_std(8'h00, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
